// File: rtl/link_param_streamer_pkg.sv
// Shared decoder-stage constants and link parameter streamer state encoding.
package link_param_streamer_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE               = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID       = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOADED,
        ST_DRAIN
    } lps_state_t;

    // Boundary code 3 is undefined on the wire and is treated as non-existent (2).
    function automatic logic [1:0] sanitize_boundary(input logic [1:0] b);
        return (b == 2'd3) ? 2'd2 : b;
    endfunction

endpackage

// File: rtl/link_result_serializer.sv
// Captures the per-link is_error vector and streams it out in RESULT_WIDTH chunks.
module link_result_serializer #(
    parameter int NUM_LINKS    = 8,
    parameter int RESULT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_LINKS-1:0]    is_error_vec,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [RESULT_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    done
);

    localparam int NCH = (NUM_LINKS + RESULT_WIDTH - 1) / RESULT_WIDTH;
    localparam int CW  = NCH * RESULT_WIDTH;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] captured;
    logic [KW-1:0] k;
    logic [KW-1:0] k_next;

    function automatic logic [RESULT_WIDTH-1:0] chunk(input logic [CW-1:0] bits,
                                                      input logic [KW-1:0] i);
        return bits[int'(i)*RESULT_WIDTH +: RESULT_WIDTH];
    endfunction

    assign k_next = k + 1'b1;
    assign done   = out_valid && out_ready && out_last;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured  <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (start) begin
            // Zero-extension pads the tail of the final chunk.
            captured  <= CW'(is_error_vec);
            k         <= '0;
            out_valid <= 1'b1;
            out_data  <= chunk(CW'(is_error_vec), '0);
            out_last  <= (NCH == 1);
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                k        <= k_next;
                out_data <= chunk(captured, k_next);
                out_last <= (k_next == KW'(NCH - 1));
            end
        end
    end

endmodule

// File: rtl/link_param_streamer.sv
// Loads per-link weight/boundary/erasure parameters from a word stream and
// returns the links' is_error flags as a chunked result stream.
module link_param_streamer
    import link_param_streamer_pkg::*;
#(
    parameter int NUM_LINKS    = 8,
    parameter int MAX_WEIGHT   = 2,
    parameter int RESULT_WIDTH = 4,
    localparam int LBW         = $clog2(MAX_WEIGHT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [STAGE_WIDTH-1:0]   global_stage,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LBW+2:0]           in_data,
    output logic [NUM_LINKS*LBW-1:0] weight_vec,
    output logic [NUM_LINKS*2-1:0]   boundary_vec,
    output logic [NUM_LINKS-1:0]     erased_vec,
    input  logic [NUM_LINKS-1:0]     is_error_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RESULT_WIDTH-1:0]  out_data,
    output logic                     out_last,
    output logic                     params_done,
    output logic                     load_error
);

    localparam int IDXW = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

    lps_state_t      state;
    logic [IDXW-1:0] idx;
    logic            stage_load;
    logic            stage_result;
    logic            accept;
    logic            enter_load;
    logic            ser_start;
    logic            ser_abort;
    logic            ser_done;
    logic [LBW-1:0]  word_weight;
    logic [LBW-1:0]  clamped_weight;

    assign stage_load   = (global_stage == STAGE_PARAMETERS_LOADING);
    assign stage_result = (global_stage == STAGE_RESULT_VALID);

    // Ready drops in the same cycle the stage leaves loading, so an aborted
    // load never completes a handshake.
    assign in_ready = (state == ST_LOAD) && stage_load;
    assign accept   = in_valid && in_ready;

    assign enter_load = stage_load && (state != ST_LOAD);
    assign ser_start  = (state == ST_LOADED) && stage_result;
    assign ser_abort  = (state == ST_DRAIN) && stage_load;

    assign word_weight    = in_data[LBW:1];
    assign clamped_weight = (int'(word_weight) > MAX_WEIGHT) ? LBW'(MAX_WEIGHT) : word_weight;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            weight_vec   <= '0;
            boundary_vec <= '0;
            erased_vec   <= '0;
            params_done  <= 1'b0;
            load_error   <= 1'b0;
        end else if (enter_load) begin
            state       <= ST_LOAD;
            idx         <= '0;
            params_done <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            case (state)
                ST_LOADED: if (stage_result) state <= ST_DRAIN;
                ST_LOAD: begin
                    if (!stage_load) begin
                        load_error <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (accept) begin
                        weight_vec[int'(idx)*LBW +: LBW]  <= clamped_weight;
                        boundary_vec[int'(idx)*2 +: 2]    <= sanitize_boundary(in_data[LBW+2:LBW+1]);
                        erased_vec[idx]                   <= in_data[0];
                        idx                               <= idx + 1'b1;
                        if (idx == IDXW'(NUM_LINKS - 1)) begin
                            state       <= ST_LOADED;
                            params_done <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: if (ser_done) state <= ST_LOADED;
                default: ;
            endcase
        end
    end

    link_result_serializer #(
        .NUM_LINKS   (NUM_LINKS),
        .RESULT_WIDTH(RESULT_WIDTH)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .start       (ser_start),
        .abort       (ser_abort),
        .is_error_vec(is_error_vec),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .done        (ser_done)
    );

endmodule

// File: tb/tb_link_param_streamer.sv
// Directed bench for link_param_streamer at NUM_LINKS=4, MAX_WEIGHT=2, RESULT_WIDTH=3.
module tb_link_param_streamer;
    import link_param_streamer_pkg::*;

    localparam int N   = 4;
    localparam int LBW = 2;
    localparam int RW  = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic                   in_valid;
    logic                   in_ready;
    logic [LBW+2:0]         in_data;
    logic [N*LBW-1:0]       weight_vec;
    logic [N*2-1:0]         boundary_vec;
    logic [N-1:0]           erased_vec;
    logic [N-1:0]           is_error_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [RW-1:0]          out_data;
    logic                   out_last;
    logic                   params_done;
    logic                   load_error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    link_param_streamer #(.NUM_LINKS(N), .MAX_WEIGHT(2), .RESULT_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .global_stage(global_stage),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .weight_vec(weight_vec), .boundary_vec(boundary_vec), .erased_vec(erased_vec),
        .is_error_vec(is_error_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .params_done(params_done), .load_error(load_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // word = {boundary, weight, erased}
    task automatic send(input logic [1:0] b, input logic [1:0] w, input logic e);
        in_valid = 1'b1;
        in_data  = {b, w, e};
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_four(input logic [1:0] b, input logic [1:0] w, input logic e);
        global_stage = STAGE_PARAMETERS_LOADING;
        step();
        for (int i = 0; i < N; i++) send(b, w, e);
    endtask

    initial begin
        reset        = 1'b1;
        global_stage = STAGE_IDLE;
        in_valid     = 1'b0;
        in_data      = '0;
        is_error_vec = '0;
        out_ready    = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_vectors", {weight_vec, boundary_vec, erased_vec}, 0);
        check("rst_flags", {params_done, load_error}, 0);
        reset = 1'b0;
        step();

        // Back-to-back load of four words.
        global_stage = STAGE_PARAMETERS_LOADING;
        step();
        check("load_in_ready", in_ready, 1);
        send(2'd0, 2'd2, 1'b0);
        send(2'd1, 2'd1, 1'b1);
        send(2'd2, 2'd2, 1'b0);
        check("load_done_early", params_done, 0);
        send(2'd0, 2'd1, 1'b0);
        check("load_done", params_done, 1);
        check("load_ready_off", in_ready, 0);
        check("load_weight", weight_vec, 8'b01_10_01_10);
        check("load_boundary", boundary_vec, 8'b00_10_01_00);
        check("load_erased", erased_vec, 4'b0010);

        // Readout with stalled consumer; source vector changes after capture.
        global_stage = STAGE_RESULT_VALID;
        is_error_vec = 4'b1011;
        step();
        is_error_vec = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            check("drain_c0_valid", out_valid, 1);
            check("drain_c0_data", out_data, 3'b011);
            check("drain_c0_last", out_last, 0);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step();
        check("drain_c1_valid", out_valid, 1);
        check("drain_c1_data", out_data, 3'b001);
        check("drain_c1_last", out_last, 1);
        step();
        check("drain_end_valid", out_valid, 0);
        check("drain_params_kept", params_done, 1);
        check("drain_weight_kept", weight_vec, 8'b01_10_01_10);
        out_ready    = 1'b0;
        global_stage = STAGE_IDLE;
        step();

        // Clamp on link 0, then abort after two words.
        global_stage = STAGE_PARAMETERS_LOADING;
        step();
        send(2'd3, 2'd3, 1'b0);
        check("clamp_weight", weight_vec[1:0], 2'd2);
        check("clamp_boundary", boundary_vec[1:0], 2'd2);
        send(2'd0, 2'd0, 1'b1);
        global_stage = STAGE_IDLE;
        step();
        check("abort_error", load_error, 1);
        check("abort_ready", in_ready, 0);
        check("abort_done", params_done, 0);
        check("abort_weight", weight_vec, 8'b01_10_00_10);
        check("abort_boundary", boundary_vec, 8'b00_10_00_10);
        check("abort_erased", erased_vec, 4'b0010);
        step();
        check("abort_error_sticky", load_error, 1);
        global_stage = STAGE_PARAMETERS_LOADING;
        step();
        check("reload_error_clr", load_error, 0);
        check("reload_in_ready", in_ready, 1);

        // Complete a load, then abandon a readout by returning to loading.
        for (int i = 0; i < N; i++) send(2'd1, 2'd1, 1'b1);
        check("full_weight", weight_vec, 8'b01_01_01_01);
        check("full_done", params_done, 1);
        global_stage = STAGE_RESULT_VALID;
        is_error_vec = 4'b0110;
        step();
        check("abandon_c0_data", out_data, 3'b110);
        check("abandon_c0_valid", out_valid, 1);
        global_stage = STAGE_PARAMETERS_LOADING;
        step();
        check("abandon_valid", out_valid, 0);
        check("abandon_in_ready", in_ready, 1);
        check("abandon_done", params_done, 0);

        // Reset in the middle of a readout.
        for (int i = 0; i < N; i++) send(2'd2, 2'd2, 1'b1);
        global_stage = STAGE_RESULT_VALID;
        is_error_vec = 4'b1111;
        step();
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b1;
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done", params_done, 0);
        check("mid_rst_vectors", {weight_vec, boundary_vec, erased_vec}, 0);
        check("mid_rst_out", {out_data, out_last}, 0);
        reset = 1'b0;
        step();
        check("post_rst_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
